// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Holds the op encoding, FSM/special-case enums and a conditional two's-complement helper.
package muldiv_pkg;

    localparam logic [1:0] MD_MULT  = 2'd0;
    localparam logic [1:0] MD_MULTU = 2'd1;
    localparam logic [1:0] MD_DIV   = 2'd2;
    localparam logic [1:0] MD_DIVU  = 2'd3;

    // Helper width; callers zero-extend into it and size-cast the result back.
    // It must be at least twice the widest operand in use.
    localparam int MD_MAXW = 128;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } md_state_e;

    typedef enum logic [1:0] {
        SP_NONE,
        SP_ZERO,
        SP_DIV0,
        SP_OVF
    } md_spec_e;

    function automatic logic [MD_MAXW-1:0] md_cneg(input logic [MD_MAXW-1:0] x,
                                                   input logic               neg);
        return neg ? (~x + MD_MAXW'(1)) : x;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide on the 2W-bit accumulator.
// Purely combinational; the caller registers acc_o.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   opnd_i,
    input  logic               div_i,
    output logic [2*WIDTH-1:0] acc_o,
    output logic               qbit_o
);

    logic [WIDTH:0]   mul_sum;
    logic [2*WIDTH:0] div_sh;
    logic [WIDTH:0]   div_diff;

    always_comb begin
        mul_sum  = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
        div_sh   = {acc_i, 1'b0};
        div_diff = div_sh[2*WIDTH:WIDTH] - {1'b0, opnd_i};
        qbit_o   = 1'b0;
        if (div_i) begin
            qbit_o = ~div_diff[WIDTH];
            // Quotient bit lands in bit 0; the caller merges qbit_o there.
            if (qbit_o) begin
                acc_o = {div_diff[WIDTH-1:0], div_sh[WIDTH-1:0]};
            end else begin
                acc_o = div_sh[2*WIDTH-1:0];
            end
        end else begin
            acc_o = {mul_sum, acc_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply/divide with HI/LO result and a one-cycle done pulse.
// WIDTH+2 cycles per operation (2 on early-out); start is ignored while busy, cancel flushes.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int W2 = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    md_state_e        state_q, state_d;
    md_spec_e         spec_q, spec_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [W2-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] op1_q, op1_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             div_q, div_d;
    logic             neg_q, neg_d;
    logic             rneg_q, rneg_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             req_mul, req_signed, s1, s2;
    logic [WIDTH-1:0] mag1, mag2;
    md_spec_e         req_spec;
    logic [W2-1:0]    step_acc, prod;
    logic             step_q;
    logic [WIDTH-1:0] quo, rem;

    always_comb begin
        req_mul    = (op == MD_MULT) || (op == MD_MULTU);
        req_signed = (op == MD_MULT) || (op == MD_DIV);
        s1         = req_signed & op1[WIDTH-1];
        s2         = req_signed & op2[WIDTH-1];
        mag1       = WIDTH'(md_cneg(MD_MAXW'(op1), s1));
        mag2       = WIDTH'(md_cneg(MD_MAXW'(op2), s2));
        if (req_mul && (op1 == '0 || op2 == '0)) begin
            req_spec = SP_ZERO;
        end else if (!req_mul && op2 == '0) begin
            req_spec = SP_DIV0;
        end else if (op == MD_DIV && op1 == MIN_NEG && op2 == '1) begin
            req_spec = SP_OVF;
        end else begin
            req_spec = SP_NONE;
        end
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc_i  (acc_q),
        .opnd_i (opnd_q),
        .div_i  (div_q),
        .acc_o  (step_acc),
        .qbit_o (step_q)
    );

    // Sign fix-up of the magnitude result held in the accumulator.
    always_comb begin
        prod = W2'(md_cneg(MD_MAXW'(acc_q), neg_q));
        quo  = WIDTH'(md_cneg(MD_MAXW'(acc_q[WIDTH-1:0]), neg_q));
        rem  = WIDTH'(md_cneg(MD_MAXW'(acc_q[W2-1:WIDTH]), rneg_q));
    end

    always_comb begin
        state_d = state_q;
        spec_d  = spec_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        op1_d   = op1_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        div_d   = div_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start && !cancel) begin
                    div_d  = !req_mul;
                    neg_d  = s1 ^ s2;
                    rneg_d = s1;
                    op1_d  = op1;
                    spec_d = req_spec;
                    cnt_d  = CW'(WIDTH - 1);
                    acc_d  = req_mul ? {{WIDTH{1'b0}}, mag2} : {{WIDTH{1'b0}}, mag1};
                    opnd_d = req_mul ? mag1 : mag2;
                    if (EARLY_OUT && (req_spec == SP_ZERO || req_spec == SP_DIV0)) begin
                        state_d = ST_FIX;
                    end else begin
                        state_d = ST_CALC;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = step_acc | {{(W2-1){1'b0}}, step_q};
                    if (cnt_q == '0) begin
                        state_d = ST_FIX;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            ST_FIX: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                    case (spec_q)
                        SP_ZERO: begin
                            hi_d = '0;
                            lo_d = '0;
                        end
                        SP_DIV0: begin
                            hi_d = op1_q;
                            lo_d = '1;
                        end
                        SP_OVF: begin
                            hi_d = '0;
                            lo_d = op1_q;
                        end
                        default: begin
                            if (div_q) begin
                                hi_d = rem;
                                lo_d = quo;
                            end else begin
                                {hi_d, lo_d} = prod;
                            end
                        end
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_CALC) || (state_d == ST_FIX);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            spec_q  <= SP_NONE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            op1_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            spec_q  <= spec_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            op1_q   <= op1_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed ops push expected HI/LO and done cycle,
// monitors pop and compare on every done pulse.
module tb_muldiv_unit;

    localparam logic [1:0] OP_MULT  = 2'd0;
    localparam logic [1:0] OP_MULTU = 2'd1;
    localparam logic [1:0] OP_DIV   = 2'd2;
    localparam logic [1:0] OP_DIVU  = 2'd3;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, start, start0, cancel;
    logic [1:0]  op;
    logic [31:0] op1, op2;
    logic        busy, done, busy0, done0;
    logic [31:0] hi, lo, hi0, lo0;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t sb0[$];
    exp_t m_e, m_e0;

    muldiv_unit #(.WIDTH(32), .EARLY_OUT(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .op1(op1), .op2(op2),
        .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    muldiv_unit #(.WIDTH(32), .EARLY_OUT(1'b0)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .op(op), .op1(op1), .op2(op2),
        .cancel(cancel), .busy(busy0), .done(done0), .hi(hi0), .lo(lo0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
            end else begin
                m_e = sb.pop_front();
                chk("hi", hi, m_e.hi);
                chk("lo", lo, m_e.lo);
                chk("done_cycle", cyc, m_e.cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (done0 === 1'b1) begin
            if (sb0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done0: got done=1 at cycle %0d expected no done", cyc);
            end else begin
                m_e0 = sb0.pop_front();
                chk("hi_noearly", hi0, m_e0.hi);
                chk("lo_noearly", lo0, m_e0.lo);
                chk("done_cycle_noearly", cyc, m_e0.cyc);
            end
        end
    end

    // Issue one op at a negedge; returns at the negedge of cycle 1 of the operation.
    task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                            input bit push, input logic [31:0] eh, input logic [31:0] el,
                            input int lat);
        exp_t e;
        op    = o;
        op1   = a;
        op2   = b;
        start = 1'b1;
        if (push) begin
            e.hi  = eh;
            e.lo  = el;
            e.cyc = cyc + lat;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL timeout_%s: got no done within 100 cycles, required a done pulse", name);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1);
    end

    initial begin
        exp_t e0;
        reset  = 1'b1;
        start  = 1'b0;
        start0 = 1'b0;
        cancel = 1'b0;
        op     = OP_MULT;
        op1    = '0;
        op2    = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_hi", hi, 0);
        chk("reset_lo", lo, 0);
        reset = 1'b0;
        @(negedge clk);

        // -3 * 7 with busy profile over cycles 1..34
        start_op(OP_MULT, 32'hFFFFFFFD, 32'd7, 1, 32'hFFFFFFFF, 32'hFFFFFFEB, 34);
        for (int k = 1; k <= 34; k++) begin
            chk($sformatf("busy_c%0d", k), busy, (k <= 33) ? 1 : 0);
            if (k < 34) @(negedge clk);
        end

        // Back-to-back starts issued while in DONE
        start_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFE, 32'h00000001, 34);
        wait_done("multu");
        start_op(OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'h00000000, 32'h00000001, 34);
        wait_done("mult_m1");
        start_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 1, 32'hFFFFFFFF, 32'hFFFFFFFD, 34);
        wait_done("div");
        start_op(OP_DIVU, 32'd100, 32'd7, 1, 32'h00000002, 32'h0000000E, 34);
        wait_done("divu");
        start_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1, 32'h00000000, 32'h80000000, 34);
        wait_done("div_ovf");

        // Divide by zero on both configurations at once
        op     = OP_DIVU;
        op1    = 32'h12345678;
        op2    = 32'h0;
        start  = 1'b1;
        start0 = 1'b1;
        e0.hi  = 32'h12345678;
        e0.lo  = 32'hFFFFFFFF;
        e0.cyc = cyc + 2;
        sb.push_back(e0);
        e0.cyc = cyc + 34;
        sb0.push_back(e0);
        @(negedge clk);
        start  = 1'b0;
        start0 = 1'b0;
        wait_done("divu_zero");
        repeat (40) @(negedge clk);

        start_op(OP_MULT, 32'h0, 32'h12345, 1, 32'h0, 32'h0, 2);
        wait_done("mult_zero");
        start_op(OP_DIV, 32'hFFFFFFF9, 32'h0, 1, 32'hFFFFFFF9, 32'hFFFFFFFF, 2);
        wait_done("div_zero");
        repeat (2) @(negedge clk);

        // Cancel during cycle 10 of a MULT
        start_op(OP_MULT, 32'd5, 32'd6, 0, 32'h0, 32'h0, 0);
        repeat (9) @(negedge clk);
        chk("cancel_busy_before", busy, 1);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel_busy_after", busy, 0);
        chk("cancel_hi_kept", hi, 32'hFFFFFFF9);
        chk("cancel_lo_kept", lo, 32'hFFFFFFFF);
        repeat (40) @(negedge clk);

        // start together with cancel in IDLE is dropped
        op     = OP_MULT;
        op1    = 32'd2;
        op2    = 32'd3;
        start  = 1'b1;
        cancel = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        cancel = 1'b0;
        chk("start_cancel_busy", busy, 0);
        repeat (40) @(negedge clk);

        // Reset in cycle 20 of a DIVU
        start_op(OP_DIVU, 32'd100, 32'd7, 0, 32'h0, 32'h0, 0);
        repeat (19) @(negedge clk);
        chk("reset_mid_busy_before", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("reset_mid_hi", hi, 0);
        chk("reset_mid_lo", lo, 0);
        chk("reset_mid_busy", busy, 0);
        repeat (40) @(negedge clk);

        start_op(OP_MULTU, 32'd6, 32'd7, 1, 32'h0, 32'h0000002A, 34);
        wait_done("multu_after_reset");
        repeat (3) @(negedge clk);

        chk("scoreboard_drained", sb.size(), 0);
        chk("scoreboard0_drained", sb0.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
